seq_gen: RTL
============

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter N_COLORS, default 4: number of colours and the one-hot output width (range 2..8).
REQ-002 SHALL have parameter DEPTH, default 16: maximum sequence length (power of 2, range 4..256).
REQ-003 SHALL have parameter SEED, default 16'hACE1: reset LFSR seed.
REQ-004 SHALL derive the localparams AW = log2(DEPTH) and CW = ceil(log2(N_COLORS)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start_i, input, 1 bit: single-cycle pulse that clears the sequence and reloads the LFSR from the seed register.
REQ-008 SHALL have port append_i, input, 1 bit: single-cycle pulse requesting one new random step.
REQ-009 SHALL have port seed_load_i, input, 1 bit: writes seed_i into the seed register.
REQ-010 SHALL have port seed_i, input, 16 bits: new seed value.
REQ-011 SHALL have port rd_en_i, input, 1 bit: read request.
REQ-012 SHALL have port rd_addr_i, input, AW bits: read index.
REQ-013 SHALL have port rd_data_o, output, N_COLORS bits: registered one-hot colour.
REQ-014 SHALL have port rd_valid_o, output, 1 bit: rd_data_o is valid.
REQ-015 SHALL have port length_o, output, AW+1 bits: number of stored steps.
REQ-016 SHALL have port full_o, output, 1 bit: asserted when length_o == DEPTH.
REQ-017 SHALL have port busy_o, output, 1 bit: asserted while the FSM is not in IDLE.

Function
REQ-018 SHALL run a 16-bit Fibonacci LFSR whose step is: fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}.
REQ-019 SHALL, on seed_load_i, store seed_i in the seed register; a value of 0 SHALL be replaced by SEED.
REQ-020 SHALL implement FSM states IDLE, DRAW and WRITE; only IDLE accepts append_i.
REQ-021 SHALL, in IDLE with append_i high and full_o low, move to DRAW; append_i SHALL be ignored when full_o is high or busy_o is high.
REQ-022 SHALL, in DRAW, step the LFSR every cycle; idx = low CW bits of the new LFSR value; if idx < N_COLORS go to WRITE, otherwise stay in DRAW (rejection).
REQ-023 SHALL, in WRITE, store idx at address length_o, increment length_o and return to IDLE.
REQ-024 SHALL, for a draw with no rejection, take an append sampled at edge k to a length_o update at edge k+2 and busy_o low after edge k+2.
REQ-025 SHALL, on start_i in any state, set length_o to 0, load the LFSR from the seed register and enter IDLE next cycle; it aborts any DRAW or WRITE and no entry is written.
REQ-026 SHALL give start_i priority over a simultaneous append_i (the append is dropped) and seed_load_i priority over start_i in the same cycle (start uses the new seed).
REQ-027 SHALL, on rd_en_i at edge k, assert rd_valid_o for the cycle after edge k and drive rd_data_o = 1<<entry[rd_addr_i] if rd_addr_i < length_o, else all zeros.
REQ-028 SHALL, when rd_en_i is low, drive rd_valid_o low and hold rd_data_o.
REQ-029 SHALL treat reads as independent of the FSM; a read and a WRITE in the same cycle SHALL use the pre-write length_o.
REQ-030 SHALL keep storage entries unreset; entries at or above length_o SHALL never be visible.

Reset
REQ-031 SHALL, with rst_n low at an edge, set the FSM to IDLE, length_o = 0, the LFSR and seed register = SEED, rd_data_o = 0, rd_valid_o = 0, and full_o = busy_o = 0.
REQ-032 SHALL give reset priority over all other inputs, including mid-DRAW or mid-WRITE.

Verification
REQ-033 SHALL cover: reset, start, then one append with defaults -> LFSR 16'h59C3, idx 3, length_o = 1; a read of address 0 gives rd_data_o = 4'b1000 with rd_valid_o = 1 one cycle later.
REQ-034 SHALL cover: 16 appends with defaults -> full_o = 1 and length_o = 16; a 17th append leaves length_o = 16 and busy_o = 0; all 16 entries match a software LFSR model and each is one-hot.
REQ-035 SHALL cover: N_COLORS = 3 with a seed that forces idx = 3 -> DRAW lasts at least 2 cycles and the stored colour is < 3.
REQ-036 SHALL cover: start_i asserted during DRAW -> length_o = 0, no write, busy_o low the next cycle.
REQ-037 SHALL cover: a read of address 5 while length_o = 2 -> rd_valid_o = 1 and rd_data_o = 0; rst_n low during WRITE -> length_o = 0.
REQ-038 SHALL cover: seed_load_i with seed_i = 0 followed by start -> the LFSR equals 16'hACE1.

Source files
------------

// File: rtl/seq_gen.sv
// Random colour-sequence generator: LFSR-driven draws appended to a small
// sequence store, with an independent registered one-hot read port.
module seq_gen #(
    parameter int          N_COLORS = 4,
    parameter int          DEPTH    = 16,
    parameter logic [15:0] SEED     = 16'hACE1,
    localparam int         AW       = $clog2(DEPTH),
    localparam int         CW       = $clog2(N_COLORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                append_i,
    input  logic                seed_load_i,
    input  logic [15:0]         seed_i,
    input  logic                rd_en_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [N_COLORS-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic [AW:0]         length_o,
    output logic                full_o,
    output logic                busy_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAW  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic [CW:0]         NC      = (CW+1)'(N_COLORS);
    localparam logic [AW:0]         DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [N_COLORS-1:0] ONE     = N_COLORS'(1);

    logic [1:0]    state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nxt;
    logic [15:0]   seed_q;
    logic [15:0]   seed_new;
    logic [CW-1:0] draw_idx;
    logic [CW-1:0] idx;
    logic [CW-1:0] mem [DEPTH];

    always_comb begin
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        draw_idx = lfsr_nxt[CW-1:0];
        // A zero seed would lock the LFSR, so it falls back to the default.
        seed_new = (seed_i == 16'd0) ? SEED : seed_i;
    end

    assign full_o = (length_o == DEPTH_L);
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            length_o <= '0;
            lfsr     <= SEED;
            seed_q   <= SEED;
            idx      <= '0;
        end else begin
            if (seed_load_i)
                seed_q <= seed_new;
            if (start_i) begin
                state    <= IDLE;
                length_o <= '0;
                lfsr     <= seed_load_i ? seed_new : seed_q;
            end else begin
                case (state)
                    IDLE: if (append_i && !full_o) state <= DRAW;
                    DRAW: begin
                        // Out-of-range indices are rejected and redrawn.
                        lfsr <= lfsr_nxt;
                        if ({1'b0, draw_idx} < NC) begin
                            idx   <= draw_idx;
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        length_o <= length_o + 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !start_i && state == WRITE)
            mem[length_o[AW-1:0]] <= idx;
    end

    // Read port sees the pre-write length, so a same-cycle write stays hidden.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else if (rd_en_i) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= ({1'b0, rd_addr_i} < length_o) ? (ONE << mem[rd_addr_i]) : '0;
        end else begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule
